// File: rtl/l1_cache_dm_if.sv
// l1_cache_dm_if: core load/store port and backing-memory port
// of the direct-mapped L1 cache, bundled with master/slave views.
interface l1_cache_dm_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  read_enable;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  flush;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  done;
  logic                  cache_ready;
  logic                  mem_read_enable;
  logic                  mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_ready;

  modport master (
    output read_enable, write_enable, address, data_in, flush,
    output mem_data_out, mem_ready,
    input  data_out, done, cache_ready,
    input  mem_read_enable, mem_write_enable, mem_address, mem_data_in
  );

  modport slave (
    input  read_enable, write_enable, address, data_in, flush,
    input  mem_data_out, mem_ready,
    output data_out, done, cache_ready,
    output mem_read_enable, mem_write_enable, mem_address, mem_data_in
  );
endinterface

// File: rtl/l1_cache_dm.sv
// l1_cache_dm: direct-mapped, write-through, no-write-allocate L1.
// Caches ROM/RAM regions only; other regions bypass to memory.
module l1_cache_dm #(
  parameter int INDEX_WIDTH   = 6,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SELECT_WIDTH  = 8,
  parameter logic [SELECT_WIDTH-1:0] ROM_SELECT = 8'h00,
  parameter logic [SELECT_WIDTH-1:0] RAM_SELECT = 8'h01,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  l1_cache_dm_if.slave             bus,
  output logic [COUNTER_WIDTH-1:0] hit_count,
  output logic [COUNTER_WIDTH-1:0] miss_count
);
  localparam int LINES = 2 ** INDEX_WIDTH;
  localparam int WW    = ADDR_WIDTH - 2;
  localparam int TW    = ADDR_WIDTH - INDEX_WIDTH - 2;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_READ, MEM_WRITE, RESPOND
  } state_t;

  state_t state, state_nx;

  logic [WW-1:0]         req_word;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_write;
  logic [DATA_WIDTH-1:0] rdata;
  logic [LINES-1:0]      valid;
  logic [TW-1:0]         tags  [LINES];
  logic [DATA_WIDTH-1:0] lines [LINES];

  logic [INDEX_WIDTH-1:0]  idx;
  logic [TW-1:0]           tag;
  logic [SELECT_WIDTH-1:0] sel;
  logic is_rom, is_ram, cacheable, hit;
  logic accept, flush_go, lookup_rd, fill, wr_hit;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^bus.address[1:0];

  assign idx       = req_word[INDEX_WIDTH-1:0];
  assign tag       = req_word[WW-1:INDEX_WIDTH];
  assign sel       = req_word[WW-1 -: SELECT_WIDTH];
  assign is_rom    = (sel == ROM_SELECT);
  assign is_ram    = (sel == RAM_SELECT);
  assign cacheable = is_rom | is_ram;
  assign hit       = valid[idx] && (tags[idx] == tag) && cacheable;

  assign flush_go  = (state == IDLE) && bus.flush;
  assign accept    = (state == IDLE) && !bus.flush &&
                     (bus.read_enable || bus.write_enable);
  assign lookup_rd = (state == LOOKUP) && !req_write;
  assign fill      = (state == MEM_READ) && bus.mem_ready && cacheable;
  assign wr_hit    = (state == LOOKUP) && req_write && is_ram && hit;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (accept) state_nx = LOOKUP;
      LOOKUP: begin
        if (req_write) state_nx = is_rom ? RESPOND : MEM_WRITE;
        else           state_nx = hit ? RESPOND : MEM_READ;
      end
      MEM_READ:  if (bus.mem_ready) state_nx = RESPOND;
      MEM_WRITE: if (bus.mem_ready) state_nx = RESPOND;
      RESPOND:   state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      valid      <= '0;
      req_word   <= '0;
      req_data   <= '0;
      req_write  <= 1'b0;
      rdata      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_word  <= bus.address[ADDR_WIDTH-1:2];
        req_data  <= bus.data_in;
        req_write <= bus.write_enable;
      end
      if (flush_go) valid <= '0;
      if (fill) valid[idx] <= 1'b1;
      if (lookup_rd && hit) begin
        rdata <= lines[idx];
        if (hit_count != '1)
          hit_count <= hit_count + COUNTER_WIDTH'(1);
      end
      if (lookup_rd && !hit && cacheable && miss_count != '1)
        miss_count <= miss_count + COUNTER_WIDTH'(1);
      if (state == MEM_READ && bus.mem_ready)
        rdata <= bus.mem_data_out;
    end
  end

  // Line data and tags carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill) begin
      lines[idx] <= bus.mem_data_out;
      tags[idx]  <= tag;
    end else if (wr_hit) begin
      lines[idx] <= req_data;
    end
  end

  assign bus.data_out         = rdata;
  assign bus.done             = (state == RESPOND);
  assign bus.cache_ready      = reset_n && (state == IDLE);
  assign bus.mem_read_enable  = (state == MEM_READ);
  assign bus.mem_write_enable = (state == MEM_WRITE);
  assign bus.mem_address      = {2'b00, req_word};
  assign bus.mem_data_in      = req_data;
endmodule

// File: tb/tb_l1_cache_dm.sv
// tb_l1_cache_dm: directed table, hand sequences and random ops
// checked against a word-level model of the cache and memory.
module tb_l1_cache_dm;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [CW-1:0] hit_count, miss_count;

  l1_cache_dm_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

  l1_cache_dm #(
    .INDEX_WIDTH(6),
    .COUNTER_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Backing memory, serviced by the responder below.
  logic [31:0] backing [logic [31:0]];
  int mem_delay = 0;
  int mem_reads = 0;
  int mem_writes = 0;
  int resp_cnt = 0;
  logic [31:0] last_maddr = '0;
  logic [31:0] last_mdata = '0;

  function automatic logic [31:0] dflt(logic [31:0] w);
    return w ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rd_backing(logic [31:0] w);
    if (backing.exists(w)) return backing[w];
    return dflt(w);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (bus.mem_read_enable || bus.mem_write_enable) begin
        if (resp_cnt >= mem_delay) begin
          resp_cnt = 0;
          bus.mem_ready = 1'b1;
          last_maddr = bus.mem_address;
          if (bus.mem_write_enable) begin
            backing[bus.mem_address] = bus.mem_data_in;
            last_mdata = bus.mem_data_in;
            mem_writes++;
          end else begin
            bus.mem_data_out = rd_backing(bus.mem_address);
            mem_reads++;
          end
        end else begin
          resp_cnt++;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // Reference model: what each word holds, which words are resident.
  logic [31:0] ref_mem [logic [31:0]];
  bit          mv [64];
  logic [31:0] mt [64];
  int          mh = 0;
  int          mm = 0;

  function automatic logic [31:0] ref_rd(logic [31:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return dflt(w);
  endfunction

  function automatic void model_clear(bit counters);
    foreach (mv[i]) mv[i] = 1'b0;
    if (counters) begin
      mh = 0;
      mm = 0;
    end
  endfunction

  function automatic void model_op(
    input bit wr, input logic [31:0] a, input logic [31:0] d,
    input int dly, output logic [31:0] ed, output int el,
    output int er, output int ew);
    logic [31:0] w;
    logic [31:0] tg;
    int idx;
    int sel;
    bit cch;
    w   = a >> 2;
    idx = int'(w % 64);
    tg  = w / 64;
    sel = int'(a >> 24);
    cch = (sel == 0) || (sel == 1);
    ed  = ref_rd(w);
    er  = 0;
    ew  = 0;
    if (wr) begin
      if (sel == 0) begin
        el = 2;
      end else begin
        ref_mem[w] = d;
        el = 3 + dly;
        ew = 1;
      end
    end else if (cch && mv[idx] && mt[idx] == tg) begin
      el = 2;
      if (mh < 15) mh++;
    end else begin
      el = 3 + dly;
      er = 1;
      if (cch) begin
        if (mm < 15) mm++;
        mv[idx] = 1'b1;
        mt[idx] = tg;
      end
    end
  endfunction

  task automatic do_op(input bit wr, input logic [31:0] a,
    input logic [31:0] d, input int dly,
    output logic [31:0] rd, output int lat);
    mem_delay = dly;
    check("ready_before_req", 32'(bus.cache_ready), 32'd1);
    bus.write_enable = wr;
    bus.read_enable  = !wr;
    bus.address      = a;
    bus.data_in      = d;
    @(negedge clk);
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.data_out;
    @(negedge clk);
  endtask

  task automatic run_model(bit wr, logic [31:0] a,
    logic [31:0] d, int dly);
    logic [31:0] ed, rd;
    int el, er, ew, lat, r0, w0;
    r0 = mem_reads;
    w0 = mem_writes;
    model_op(wr, a, d, dly, ed, el, er, ew);
    do_op(wr, a, d, dly, rd, lat);
    if (!wr) check("model_data", rd, ed);
    check("model_latency", lat, el);
    check("model_mem_reads", mem_reads - r0, er);
    check("model_mem_writes", mem_writes - w0, ew);
    check("model_hit_count", 32'(hit_count), mh);
    check("model_miss_count", 32'(miss_count), mm);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    model_clear(1'b1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_maddr;
    int          exp_hit;
    int          exp_miss;
  } vec_t;

  initial begin
    vec_t tbl [10];
    logic [31:0] ed, rd;
    int el, er, ew, lat, r0, w0, dones;

    tbl[0] = '{0, 32'h0100_0010, 0, 3, 32'hDEAD_BEEF, 6, 1, 0,
               32'h0040_0004, 0, 1};
    tbl[1] = '{0, 32'h0100_0010, 0, 3, 32'hDEAD_BEEF, 2, 0, 0,
               32'h0, 1, 1};
    tbl[2] = '{1, 32'h0100_0010, 32'h1234_5678, 1, 32'h0, 4, 0, 1,
               32'h0040_0004, 1, 1};
    tbl[3] = '{0, 32'h0100_0010, 0, 0, 32'h1234_5678, 2, 0, 0,
               32'h0, 2, 1};
    tbl[4] = '{0, 32'h0100_0000, 0, 0, 32'h5A1A_0000, 3, 1, 0,
               32'h0040_0000, 2, 2};
    tbl[5] = '{0, 32'h0100_0100, 0, 0, 32'h5A1A_0040, 3, 1, 0,
               32'h0040_0040, 2, 3};
    tbl[6] = '{0, 32'h0100_0000, 0, 2, 32'h5A1A_0000, 5, 1, 0,
               32'h0040_0000, 2, 4};
    tbl[7] = '{0, 32'h0200_0000, 0, 1, 32'h5ADA_0000, 4, 1, 0,
               32'h0080_0000, 2, 4};
    tbl[8] = '{0, 32'h0200_0000, 0, 1, 32'h5ADA_0000, 4, 1, 0,
               32'h0080_0000, 2, 4};
    tbl[9] = '{1, 32'h0000_0040, 32'hCAFE_F00D, 1, 32'h0, 2, 0, 0,
               32'h0, 2, 4};

    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;
    bus.address      = '0;
    bus.data_in      = '0;
    bus.flush        = 1'b0;
    bus.mem_ready    = 1'b0;
    bus.mem_data_out = '0;
    backing[32'h0040_0004] = 32'hDEAD_BEEF;
    ref_mem[32'h0040_0004] = 32'hDEAD_BEEF;
    model_clear(1'b1);

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(bus.cache_ready), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_mem_rd", 32'(bus.mem_read_enable), 32'd0);
    check("reset_mem_wr", 32'(bus.mem_write_enable), 32'd0);
    check("reset_data_out", bus.data_out, 32'd0);
    check("reset_hits", 32'(hit_count), 32'd0);
    check("reset_misses", 32'(miss_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.cache_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      r0 = mem_reads;
      w0 = mem_writes;
      model_op(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].dly,
               ed, el, er, ew);
      do_op(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].dly, rd, lat);
      if (!tbl[i].wr) check("tbl_data", rd, tbl[i].exp_data);
      check("tbl_latency", lat, tbl[i].exp_lat);
      check("tbl_mem_reads", mem_reads - r0, tbl[i].exp_rd);
      check("tbl_mem_writes", mem_writes - w0, tbl[i].exp_wr);
      if (tbl[i].exp_rd + tbl[i].exp_wr > 0)
        check("tbl_mem_address", last_maddr, tbl[i].exp_maddr);
      if (tbl[i].exp_wr > 0)
        check("tbl_mem_data_in", last_mdata, tbl[i].wdata);
      check("tbl_hit_count", 32'(hit_count), tbl[i].exp_hit);
      check("tbl_miss_count", 32'(miss_count), tbl[i].exp_miss);
    end

    // Flush wins over a simultaneous read.
    r0 = mem_reads;
    bus.flush       = 1'b1;
    bus.read_enable = 1'b1;
    bus.address     = 32'h0100_0010;
    @(negedge clk);
    bus.flush       = 1'b0;
    bus.read_enable = 1'b0;
    check("flush_stays_idle", 32'(bus.cache_ready), 32'd1);
    check("flush_no_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("flush_no_mem_rd", 32'(bus.mem_read_enable), 32'd0);
    check("flush_no_mem_reads", mem_reads - r0, 32'd0);
    model_clear(1'b0);
    run_model(1'b0, 32'h0100_0010, 32'h0, 0);
    check("flush_miss_count", 32'(miss_count), 32'd5);

    // Reset during MEM_READ aborts with no done pulse.
    mem_delay = 10;
    bus.read_enable = 1'b1;
    bus.address     = 32'h0100_0020;
    @(negedge clk);
    bus.read_enable = 1'b0;
    @(negedge clk);
    check("abort_in_mem_read", 32'(bus.mem_read_enable), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_mem_rd_drop", 32'(bus.mem_read_enable), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_hits", 32'(hit_count), 32'd0);
    check("abort_misses", 32'(miss_count), 32'd0);
    reset_n = 1'b1;
    model_clear(1'b1);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort_no_done_after", dones, 32'd0);
    check("abort_ready", 32'(bus.cache_ready), 32'd1);

    // Hit counter saturates rather than wrapping.
    run_model(1'b0, 32'h0100_0080, 32'h0, 1);
    for (int i = 0; i < 17; i++)
      run_model(1'b0, 32'h0100_0080, 32'h0, 1);
    check("sat_hit_count", 32'(hit_count), 32'd15);
    check("sat_miss_count", 32'(miss_count), 32'd1);

    do_reset();
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      logic [31:0] sel;
      int s;
      s = $urandom_range(0, 3);
      sel = (s == 0) ? 32'h00 : (s == 1) ? 32'h01 :
            (s == 2) ? 32'h02 : 32'hF0;
      a = (sel << 24) | (32'($urandom_range(0, 2)) << 8) |
          (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      run_model($urandom_range(0, 9) < 3, a, $urandom,
                $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/l1_cache_dm.md
Name: l1_cache_dm

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate L1 cache with one word per line.
- Sits between the core load/store port and a single word-addressed backing-memory port.
- Caches only the ROM (select 8'h00) and RAM (select 8'h01) regions; all other addresses bypass to memory.
- Adds over the previous generation: real tag/valid arrays, a miss FSM with memory handshake, flush, and hit/miss performance counters.

Parameters:
- INDEX_WIDTH, 6: log2 of line count; 2**INDEX_WIDTH lines.
- ADDR_WIDTH, 32: byte address width; tag width = ADDR_WIDTH-INDEX_WIDTH-2.
- DATA_WIDTH, 32: word width.
- SELECT_WIDTH, 8: address MSBs used for region select.
- ROM_SELECT, 8'h00: ROM region select value (cacheable, read-only).
- RAM_SELECT, 8'h01: RAM region select value (cacheable).
- COUNTER_WIDTH, 16: width of the saturating hit/miss counters.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- read_enable  in  1  read request; sampled only while cache_ready=1.
- write_enable  in  1  write request; wins over read_enable if both are high.
- address  in  ADDR_WIDTH  byte address; bits[1:0] are ignored.
- data_in  in  DATA_WIDTH  write data.
- flush  in  1  invalidate all lines; sampled only while cache_ready=1.
- data_out  out  DATA_WIDTH  read data, valid during the done pulse.
- done  out  1  one-cycle completion pulse.
- cache_ready  out  1  high only in IDLE.
- mem_read_enable  out  1  backing-memory read request.
- mem_write_enable  out  1  backing-memory write request.
- mem_address  out  ADDR_WIDTH  word address {2'b0, addr[ADDR_WIDTH-1:2]}.
- mem_data_in  out  DATA_WIDTH  write data to memory.
- mem_data_out  in  DATA_WIDTH  read data from memory.
- mem_ready  in  1  one-cycle acknowledge of the current memory request.
- hit_count  out  COUNTER_WIDTH  saturating count of read hits.
- miss_count  out  COUNTER_WIDTH  saturating count of cacheable read misses.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, all valid bits cleared, all outputs 0, counters 0. cache_ready rises the first cycle after reset releases.
- Reset mid-operation aborts the transaction: mem enables drop on the next edge and no done pulse is issued.
- States: IDLE, LOOKUP, MEM_READ, MEM_WRITE, RESPOND.
- IDLE:
  - flush=1 clears all valid bits in one cycle and the FSM stays in IDLE; flush has priority over a simultaneous request, which is ignored.
  - Otherwise a request latches address, data_in and op, then goes to LOOKUP.
- LOOKUP: compare stored tag and valid bit at the latched index; a hit is valid && tag match && cacheable.
  - Read hit: data_out=line data; go to RESPOND; hit_count+1.
  - Cacheable read miss: go to MEM_READ; miss_count+1.
  - Uncacheable read: go to MEM_READ; no counter change.
  - Write to RAM region: on hit, update line data in this cycle; go to MEM_WRITE. On miss, no allocate.
  - Write to ROM region: dropped; go to RESPOND; cache untouched.
  - Write to any other region: go to MEM_WRITE.
- MEM_READ: mem_read_enable=1 and mem_address held until mem_ready.
  - On the mem_ready cycle: capture mem_data_out into data_out, go to RESPOND.
  - If cacheable, also write line data/tag and set valid.
- MEM_WRITE: mem_write_enable=1, mem_address and mem_data_in held until mem_ready; on mem_ready go to RESPOND.
- RESPOND: done=1 for exactly one cycle, then IDLE. data_out holds its value until the next read completes.
- Latency, counting the accept edge as cycle 0:
  - Read hit: done in cycle 2.
  - Read miss or write: done one cycle after the mem_ready cycle.
  - mem_ready arriving in the first MEM_* cycle is legal.
- mem_ready outside MEM_READ/MEM_WRITE is ignored.
- Counters saturate at all-ones; they do not wrap.
- Line data and tags need no reset; only valid bits are reset.

Test Plan:
- Reset, then read 0x0100_0010 with memory returning 0xDEADBEEF and mem_ready 3 cycles after request. Required: mem_address=0x0040_0004, done with data_out=0xDEADBEEF, miss_count=1. Repeat the same read: done at cycle 2, no mem request, hit_count=1.
- Write 0x1234_5678 to 0x0100_0010 after it is cached. Required: mem_write_enable with mem_data_in=0x12345678. A subsequent read hits and returns 0x12345678.
- Aliasing, INDEX_WIDTH=6: read 0x0100_0000, then 0x0100_0100 (same index, different tag). Required: both miss. Re-reading 0x0100_0000 misses again.
- Pulse flush in IDLE while read_enable is also high. Required: request ignored, all lines invalid, next read of a previously cached address misses.
- Read 0x0200_0000 (uncacheable) twice. Required: two memory reads, counters unchanged. Write to 0x0000_0040 (ROM). Required: no mem_write_enable, done pulse after 2 cycles.
- Assert reset_n=0 during MEM_READ. Required: mem_read_enable=0 the next cycle, no done pulse, counters=0. Force hit_count near all-ones. Required: it saturates at all-ones and does not wrap.
